ble_uart_rx: RTL and testbench

- 8N1 UART receiver with RTS flow control for the BLE PMOD on junction A.
- Input is the module's TXD (JA3); the RTS output drives JA1. It is the receive-side counterpart of the FPGA-to-BLE transmit path (JA2).
- Oversamples the line 16x, deframes bytes and buffers them in a show-ahead FIFO.
- Presents bytes to the core-side peripheral with a valid/ready handshake. Runs in the clk_core domain.

---
 rtl/ble_uart_rx.sv | 196 +++++++++++++++++++
 tb/tb_ble_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ble_uart_rx.sv
// 8N1 UART receiver for the BLE PMOD (junction A): 16x oversampling deframer,
// show-ahead byte FIFO with valid/ready read side, RTS flow control toward the
// BLE module and sticky framing/overrun flags. Single clock domain (clk_core).
module ble_uart_rx #(
   parameter int unsigned OVS_DIV      = 27,  // clk cycles per 16x oversample tick
   parameter int unsigned FIFO_DEPTH   = 16,  // power of 2
   parameter int unsigned RTS_HI_WATER = 12   // occupancy at which o_rts_n goes high
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_rxd,
   output logic                          o_rts_n,
   output logic [7:0]                    o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_frame_err,
   output logic                          o_overrun,
   input  logic                          i_clr_err
);

   localparam int unsigned DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_e;

   // Synchronizer and timebase
   logic             rxd_meta_q, rxd_meta_d;
   logic             rxs_q, rxs_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   // Deframer
   state_e           state_q, state_d;
   logic             prev_smp_q, prev_smp_d;
   logic [3:0]       smp_cnt_q, smp_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             push_req;
   logic             frame_set;

   // FIFO and status
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             rts_n_q, rts_n_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             full;
   logic             pop;
   logic             push;

   assign tick = (div_q == DIV_W'(OVS_DIV - 1));

   // Two-flop synchronizer on the asynchronous line and free-running tick divider
   always_comb begin
      rxd_meta_d = i_rxd;
      rxs_d      = rxd_meta_q;
      div_d      = tick ? '0 : div_q + DIV_W'(1);
   end

   // Deframer FSM: advances only on oversample ticks, holds between them
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // one unassigned and no latch is inferred.
      state_d    = state_q;
      prev_smp_d = prev_smp_q;
      smp_cnt_d  = smp_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      push_req   = 1'b0;
      frame_set  = 1'b0;
      if (tick) begin
         prev_smp_d = rxs_q;
         smp_cnt_d  = smp_cnt_q + 4'd1;
         case (state_q)
            ST_IDLE: begin
               // A falling edge between two ticks marks a candidate start bit.
               // prev_smp resets to 0, so a line already low at reset release
               // must first be seen high before a start can be recognised.
               if (!rxs_q && prev_smp_q) begin
                  smp_cnt_d = '0;
                  state_d   = ST_START;
               end
            end
            ST_START: begin
               if (smp_cnt_q == 4'd7) begin
                  if (!rxs_q) begin
                     smp_cnt_d = '0;
                     bit_idx_d = '0;
                     state_d   = ST_DATA;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (smp_cnt_q == 4'd15) begin
                  shift_d   = {rxs_q, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_d = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               // Leave at mid stop bit so a back-to-back start edge is not missed.
               if (smp_cnt_q == 4'd15) begin
                  state_d = ST_IDLE;
                  if (rxs_q) begin
                     push_req = 1'b1;
                  end else begin
                     frame_set = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FIFO bookkeeping, RTS threshold and sticky error flags
   always_comb begin
      pop      = (count_q != '0) && i_ready;
      full     = (count_q == CNT_W'(FIFO_DEPTH));
      push     = push_req && (!full || pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rts_n_d  = (count_d >= CNT_W'(RTS_HI_WATER));
      // A set event in the same cycle as a clear takes priority.
      frame_err_d = frame_set | (frame_err_q & ~i_clr_err);
      overrun_d   = (push_req & full & ~pop) | (overrun_q & ~i_clr_err);
   end

   // State registers, all returned to idle values by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta_q  <= 1'b1;
         rxs_q       <= 1'b1;
         div_q       <= '0;
         state_q     <= ST_IDLE;
         prev_smp_q  <= 1'b0;
         smp_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rts_n_q     <= 1'b1;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // present before the edge, independent of statement order.
         rxd_meta_q  <= rxd_meta_d;
         rxs_q       <= rxs_d;
         div_q       <= div_d;
         state_q     <= state_d;
         prev_smp_q  <= prev_smp_d;
         smp_cnt_q   <= smp_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rts_n_q     <= rts_n_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // FIFO storage write port
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; entries are only observable once counted
      // as valid, and o_data is forced to zero while the FIFO is empty.
      if (push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign o_data      = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
   assign o_valid     = (count_q != '0);
   assign o_count     = count_q;
   assign o_rts_n     = rts_n_q;
   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_ble_uart_rx.sv
// Directed self-checking bench for ble_uart_rx at OVS_DIV=27 (432 clk per bit).
`timescale 1ns/1ps
module tb_ble_uart_rx;

   localparam int OVS     = 27;
   localparam int BIT     = 16 * OVS;
   localparam int DEPTH   = 16;
   localparam int HI      = 12;
   // Stop mid-sample is 9.5 bits after detection; detection lags the edge by
   // the 2-flop synchronizer plus at most one tick.
   localparam int LAT_MIN = 9 * BIT;
   localparam int LAT_MAX = (19 * BIT) / 2 + OVS + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_rxd;
   logic       i_ready;
   logic       i_clr_err;
   logic       o_rts_n;
   logic [7:0] o_data;
   logic       o_valid;
   logic [4:0] o_count;
   logic       o_frame_err;
   logic       o_overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int rts_viol = 0;
   int lat      = -1;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   ble_uart_rx #(
      .OVS_DIV      (OVS),
      .FIFO_DEPTH   (DEPTH),
      .RTS_HI_WATER (HI)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rxd       (i_rxd),
      .o_rts_n     (o_rts_n),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_count     (o_count),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .i_clr_err   (i_clr_err)
   );

   // RTS must always reflect the registered occupancy against the high-water mark
   always @(negedge clk) begin
      if (mon_en && (o_rts_n !== (o_count >= 5'(HI)))) rts_viol++;
   end

   // Global time bound
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one
   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      i_rxd = b;
      clks(BIT);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit(stop);
   endtask

   task automatic pop_one();
      i_ready = 1'b1;
      clks(1);
      i_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      i_clr_err = 1'b1;
      clks(1);
      i_clr_err = 1'b0;
   endtask

   initial begin
      logic [7:0] b2b [3];
      b2b[0] = 8'h00;
      b2b[1] = 8'hFF;
      b2b[2] = 8'h81;

      rst = 1'b1; i_rxd = 1'b1; i_ready = 1'b0; i_clr_err = 1'b0;
      clks(3);

      // Reset state
      check("rst_rts_n",     o_rts_n,     1'b1);
      check("rst_valid",     o_valid,     1'b0);
      check("rst_count",     o_count,     5'd0);
      check("rst_data",      o_data,      8'h00);
      check("rst_frame_err", o_frame_err, 1'b0);
      check("rst_overrun",   o_overrun,   1'b0);
      rst = 1'b0;
      clks(1);
      check("rts_after_release", o_rts_n, 1'b0);
      clks(2 * BIT);

      // Single byte with latency window from the start edge
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int c = 1; c <= LAT_MAX; c++) begin
               @(posedge clk);
               #1;
               if (o_valid && lat < 0) lat = c;
            end
         end
      join
      check("a5_latency_window", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1'b1);
      check("a5_valid",     o_valid,     1'b1);
      check("a5_data",      o_data,      8'hA5);
      check("a5_count",     o_count,     5'd1);
      check("a5_frame_err", o_frame_err, 1'b0);
      check("a5_overrun",   o_overrun,   1'b0);
      pop_one();
      check("a5_drained_count", o_count, 5'd0);
      check("a5_drained_valid", o_valid, 1'b0);

      // Framing error: stop bit low
      send_frame(8'h3C, 1'b0);
      send_bit(1'b1);
      check("ferr_count", o_count,     5'd0);
      check("ferr_valid", o_valid,     1'b0);
      check("ferr_flag",  o_frame_err, 1'b1);
      check("ferr_no_ovr", o_overrun,  1'b0);
      pulse_clr();
      check("ferr_cleared", o_frame_err, 1'b0);

      // Glitch rejection followed by a clean frame
      i_rxd = 1'b0;
      clks(100);
      i_rxd = 1'b1;
      clks(BIT);
      check("glitch_count", o_count,     5'd0);
      check("glitch_ferr",  o_frame_err, 1'b0);
      send_frame(8'h55, 1'b1);
      check("g55_valid", o_valid, 1'b1);
      check("g55_data",  o_data,  8'h55);
      check("g55_count", o_count, 5'd1);
      pop_one();

      // Back-to-back frames with no idle gap
      for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1);
      check("b2b_count", o_count, 5'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_data_%0d", i), o_data, b2b[i]);
         pop_one();
      end
      check("b2b_empty", o_count, 5'd0);
      check("b2b_ferr",  o_frame_err, 1'b0);
      clks(BIT);

      // Flow control and overrun: 17 bytes, consumer stalled
      mon_en = 1'b1;
      for (int k = 0; k < 17; k++) begin
         send_frame(8'(k), 1'b1);
         check($sformatf("fc_count_%0d", k), o_count, (k < DEPTH) ? k + 1 : DEPTH);
         if (k == 10) check("fc_rts_at_11", o_rts_n, 1'b0);
         if (k == 11) check("fc_rts_at_12", o_rts_n, 1'b1);
         if (k == 15) check("fc_no_ovr_at_16", o_overrun, 1'b0);
      end
      check("fc_overrun", o_overrun,   1'b1);
      check("fc_ferr",    o_frame_err, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("drain_data_%0d", i), o_data, 8'(i));
         pop_one();
         check($sformatf("drain_count_%0d", i), o_count, DEPTH - 1 - i);
         check($sformatf("drain_rts_%0d", i), o_rts_n, (DEPTH - 1 - i) >= HI);
      end
      check("drain_empty", o_valid, 1'b0);
      mon_en = 1'b0;
      check("rts_tracks_count", rts_viol, 0);
      check("overrun_still_set", o_overrun, 1'b1);

      // Reset during bit 4 of 0xC3, line held low through release
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0);
      i_rxd = 1'b0;
      clks(BIT / 2);
      rst = 1'b1;
      clks(2);
      check("mrst_rts_n",     o_rts_n,     1'b1);
      check("mrst_valid",     o_valid,     1'b0);
      check("mrst_count",     o_count,     5'd0);
      check("mrst_data",      o_data,      8'h00);
      check("mrst_frame_err", o_frame_err, 1'b0);
      check("mrst_overrun",   o_overrun,   1'b0);
      rst = 1'b0;
      clks(2 * BIT);
      i_rxd = 1'b1;
      clks(10 * BIT);
      check("mrst_no_push", o_count,     5'd0);
      check("mrst_no_ferr", o_frame_err, 1'b0);
      send_frame(8'h42, 1'b1);
      check("post_rst_valid", o_valid, 1'b1);
      check("post_rst_data",  o_data,  8'h42);
      check("post_rst_count", o_count, 5'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
